// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port integer register file with a write-back scoreboard.
//   NRD combinational read ports, NWR synchronous write ports, register 0
//   hardwired to zero, optional write-to-read bypass, and one busy bit per
//   register used by a pipelined core to detect RAW hazards.
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   wr_en/wr_addr/wr_data   NWR write ports, port k in slice k (packed)
//   rd_addr -> rd_data      NRD read ports, combinational
//   rd_busy                 busy flag of each read-addressed register
//   sb_set_en/sb_set_addr   mark a register busy (instruction issued)
//   busy_vec                registered busy flags, bit i = register i
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                sb_set_en,
  input  logic [AW-1:0]       sb_set_addr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;
  logic [NWR-1:0]   w_wr_valid;

  // A write to address 0 is not a write at all: it neither stores nor
  // clears busy, and never bypasses.
  genvar gi;
  generate
    for (gi = 0; gi < NWR; gi++) begin : g_wr_valid
      assign w_wr_valid[gi] = wr_en[gi] && (wr_addr[gi*AW +: AW] != '0);
    end
  endgenerate

  // Retiring writes clear busy first; an issue to the same register in the
  // same cycle is applied afterwards so the newer producer stays tracked.
  always_comb begin
    w_busy_next = r_busy;
    for (int k = 0; k < NWR; k++) begin
      if (w_wr_valid[k]) begin
        w_busy_next[wr_addr[k*AW +: AW]] = 1'b0;
      end
    end
    if (sb_set_en && (sb_set_addr != '0)) begin
      w_busy_next[sb_set_addr] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  // Ascending port order means the highest-index port's store lands last.
  // Register 0 is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (w_wr_valid[k]) begin
          r_regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
        end
      end
      r_busy <= w_busy_next;
    end
  end

  assign busy_vec = r_busy;

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   w_ra;
      logic [XLEN-1:0] w_data;
      logic            w_hit;

      assign w_ra = rd_addr[gi*AW +: AW];

      // Bypass is suppressed while reset is held so reads return zero
      // even when the write inputs are still active.
      always_comb begin
        w_data = r_regs[w_ra];
        w_hit  = 1'b0;
        if ((BYPASS != 0) && reset_n) begin
          for (int k = 0; k < NWR; k++) begin
            if (w_wr_valid[k] && (wr_addr[k*AW +: AW] == w_ra)) begin
              w_data = wr_data[k*XLEN +: XLEN];
              w_hit  = 1'b1;
            end
          end
        end
      end

      assign rd_data[gi*XLEN +: XLEN] = w_data;
      assign rd_busy[gi]              = r_busy[w_ra] & ~w_hit;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: runs a BYPASS=1 and a BYPASS=0 instance on the
// same stimulus and checks both against a behavioural register-file model.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic                clk;
  logic                reset_n;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic                sb_set_en;
  logic [AW-1:0]       sb_set_addr;

  logic [NRD*XLEN-1:0] rd_data1, rd_data0;
  logic [NRD-1:0]      rd_busy1, rd_busy0;
  logic [NREGS-1:0]    busy_vec1, busy_vec0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_busy;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_byp (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_vec(busy_vec1)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nobyp (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_vec(busy_vec0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  // Expected read data for port j: stored value, or with bypass the value
  // of the highest write port targeting the same nonzero address.
  function automatic logic [31:0] exp_data(input int j, input bit byp);
    logic [AW-1:0] a;
    logic [31:0]   d;
    a = rd_addr[j*AW +: AW];
    if (!reset_n || a == 0) return 32'h0;
    d = m_regs[a];
    if (byp) begin
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && wr_addr[k*AW +: AW] == a) d = wr_data[k*XLEN +: XLEN];
    end
    return d;
  endfunction

  function automatic logic [31:0] exp_busy(input int j, input bit byp);
    logic [AW-1:0] a;
    bit            b;
    a = rd_addr[j*AW +: AW];
    if (!reset_n || a == 0) return 32'h0;
    b = m_busy[a];
    if (byp) begin
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && wr_addr[k*AW +: AW] == a) b = 1'b0;
    end
    return {31'h0, b};
  endfunction

  task automatic model_edge();
    logic [AW-1:0] a;
    for (int k = 0; k < NWR; k++) begin
      a = wr_addr[k*AW +: AW];
      if (wr_en[k] && a != 0) begin
        m_regs[a] = wr_data[k*XLEN +: XLEN];
        m_busy[a] = 1'b0;
      end
    end
    if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
  endtask

  task automatic check_outputs(input string ctx);
    for (int j = 0; j < NRD; j++) begin
      check($sformatf("%s byp rd_data[%0d] a=%0d", ctx, j, rd_addr[j*AW +: AW]),
            rd_data1[j*XLEN +: XLEN], exp_data(j, 1'b1));
      check($sformatf("%s nobyp rd_data[%0d] a=%0d", ctx, j, rd_addr[j*AW +: AW]),
            rd_data0[j*XLEN +: XLEN], exp_data(j, 1'b0));
      check($sformatf("%s byp rd_busy[%0d]", ctx, j), {31'h0, rd_busy1[j]}, exp_busy(j, 1'b1));
      check($sformatf("%s nobyp rd_busy[%0d]", ctx, j), {31'h0, rd_busy0[j]}, exp_busy(j, 1'b0));
    end
    check($sformatf("%s byp busy_vec", ctx), busy_vec1, reset_n ? m_busy : 32'h0);
    check($sformatf("%s nobyp busy_vec", ctx), busy_vec0, reset_n ? m_busy : 32'h0);
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are checked
  // mid-cycle, then the model advances on the edge.
  task automatic cycle(input string ctx);
    #2;
    check_outputs(ctx);
    $display("cycle %s wr_en=%b wr_addr=%h wr_data=%h rd_addr=%h set=%b/%0d",
             ctx, wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr);
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; sb_set_en = 1'b0; sb_set_addr = '0;
  endtask

  task automatic randomize_inputs();
    wr_en       = NWR'($urandom);
    wr_addr     = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
    wr_data     = {$urandom, $urandom};
    sb_set_en   = 1'($urandom);
    sb_set_addr = AW'($urandom_range(0, 15));
    rd_addr     = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
    if ($urandom_range(0, 2) == 0) rd_addr[AW-1:0] = wr_addr[AW-1:0];
    if ($urandom_range(0, 2) == 0) rd_addr[2*AW-1:AW] = wr_addr[2*AW-1:AW];
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    rd_addr = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Read every address after reset.
    for (int a = 0; a < NREGS; a += 2) begin
      rd_addr = {AW'(a + 1), AW'(a)};
      cycle("reset_read");
    end

    // Plain write, then read back alongside register 0.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    rd_addr = '0;
    cycle("wr5");
    idle();
    rd_addr = {5'd0, 5'd5};
    #2;
    check("reg5_nobyp", rd_data0[31:0], 32'hDEADBEEF);
    check("reg0_port1", rd_data1[63:32], 32'h0);
    cycle("rd5");

    // Writes to register 0 are dropped, including on the bypass path.
    wr_en = 2'b10; wr_addr = {5'd0, 5'd0}; wr_data = {32'h1234, 32'h0};
    rd_addr = {5'd0, 5'd0};
    #2;
    check("reg0_byp_same_cycle", rd_data1[63:32], 32'h0);
    cycle("wr0");
    idle();
    #2;
    check("reg0_after_write", rd_data0[31:0], 32'h0);
    cycle("rd0");

    // Two ports write the same register: highest port wins.
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
    rd_addr = {5'd7, 5'd7};
    #2;
    check("reg7_byp_same_cycle", rd_data1[31:0], 32'h22);
    check("reg7_nobyp_same_cycle", rd_data0[31:0], 32'h0);
    cycle("wr7");
    idle();
    #2;
    check("reg7_after", rd_data0[63:32], 32'h22);
    cycle("rd7");

    // Scoreboard set, then clear by write-back.
    sb_set_en = 1'b1; sb_set_addr = 5'd3; rd_addr = {5'd0, 5'd3};
    #2;
    check("reg3_busy_not_yet", {31'h0, rd_busy1[0]}, 32'h0);
    cycle("set3");
    idle();
    #2;
    check("reg3_busy", {31'h0, rd_busy1[0]}, 32'h1);
    check("busy_vec3", {31'h0, busy_vec1[3]}, 32'h1);
    cycle("rd3");
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h55};
    #2;
    check("reg3_byp_busy_cleared", {31'h0, rd_busy1[0]}, 32'h0);
    check("reg3_byp_data", rd_data1[31:0], 32'h55);
    check("reg3_nobyp_busy_still", {31'h0, rd_busy0[0]}, 32'h1);
    cycle("wr3");
    idle();
    #2;
    check("busy_vec3_cleared", {31'h0, busy_vec0[3]}, 32'h0);
    cycle("rd3b");

    // Set and clear of the same register in one cycle: set wins.
    sb_set_en = 1'b1; sb_set_addr = 5'd9; rd_addr = {5'd9, 5'd0};
    cycle("set9");
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h99, 32'h0};
    cycle("set_wr9");
    idle();
    #2;
    check("busy_vec9_set_wins", {31'h0, busy_vec1[9]}, 32'h1);
    check("reg9_data", rd_data0[63:32], 32'h99);
    cycle("rd9");

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      cycle("rand");
    end

    // Asynchronous reset in the middle of active traffic.
    randomize_inputs();
    wr_en = 2'b11; wr_addr = {5'd4, 5'd6}; sb_set_en = 1'b1; sb_set_addr = 5'd8;
    rd_addr = {5'd4, 5'd6};
    #2 reset_n = 1'b0;
    model_clear();
    #1;
    check_outputs("async_reset");
    @(posedge clk);
    #1;
    check_outputs("reset_hold");
    idle();
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int a = 0; a < 16; a += 2) begin
      rd_addr = {AW'(a + 1), AW'(a)};
      cycle("post_reset_read");
    end

    for (int i = 0; i < 100; i++) begin
      randomize_inputs();
      cycle("rand2");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
